// File: rtl/bus_slave_regfile.sv
// bus_slave_regfile: small parity-protected register file behind a strobe-based
// bus. A request is latched in IDLE, executed in ACCESS, acknowledged in RESP and
// the slave then parks in RELEASE until both strobes are released so that a
// held strobe is serviced only once. All outputs come straight from flops.
module bus_slave_regfile #(
    parameter int                    BUS_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'hF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  rb_n,
    input  logic                  wb_n,
    input  logic [BUS_WIDTH-1:0]  data_in,
    input  logic                  parity_in,
    output logic [BUS_WIDTH-1:0]  data_out,
    output logic                  data_oe,
    output logic                  parity_out,
    output logic                  ack_n,
    output logic                  err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Address window widened by one bit so BASE_ADDR+DEPTH-1 cannot wrap.
    localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_ILLEGAL = 2'd2
    } op_t;

    // Even parity: XOR of all data bits.
    function automatic logic parity_f(input logic [BUS_WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t                 state_r;
    state_t                 state_nx_s;
    op_t                    op_r;
    logic [IDX_W-1:0]       idx_r;
    logic [BUS_WIDTH-1:0]   wdata_r;
    logic                   wpar_r;
    logic                   bad_r;
    logic [BUS_WIDTH-1:0]   regs_r [DEPTH];
    logic [BUS_WIDTH-1:0]   data_out_r;
    logic                   data_oe_r;
    logic                   parity_out_r;
    logic                   ack_n_r;
    logic                   err_r;

    logic [ADDR_WIDTH:0]    addr_ext_s;
    logic                   hit_s;
    logic [IDX_W-1:0]       idx_s;
    logic                   req_s;

    // Address decode and request qualification.
    always_comb begin
        addr_ext_s = {1'b0, address};
        hit_s      = (addr_ext_s >= LO_ADDR) && (addr_ext_s <= HI_ADDR);
        idx_s      = IDX_W'(address - BASE_ADDR);
        req_s      = hit_s && !(rb_n && wb_n);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; RELEASE waits for both strobes high before re-arming.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nx_s = ACCESS;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCESS:  state_nx_s = RESP;
            RESP:    state_nx_s = RELEASE;
            RELEASE: begin
                if (rb_n && wb_n) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RELEASE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Request capture, register access and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r         <= OP_READ;
            idx_r        <= '0;
            wdata_r      <= '0;
            wpar_r       <= 1'b0;
            bad_r        <= 1'b0;
            data_out_r   <= '0;
            parity_out_r <= 1'b0;
            data_oe_r    <= 1'b0;
            ack_n_r      <= 1'b1;
            err_r        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        idx_r   <= idx_s;
                        wdata_r <= data_in;
                        wpar_r  <= parity_in;
                        if (!rb_n && !wb_n) begin
                            op_r <= OP_ILLEGAL;
                        end else if (!wb_n) begin
                            op_r <= OP_WRITE;
                        end else begin
                            op_r <= OP_READ;
                        end
                    end
                end
                ACCESS: begin
                    case (op_r)
                        OP_WRITE: begin
                            if (parity_f(wdata_r) == wpar_r) begin
                                regs_r[idx_r] <= wdata_r;
                                bad_r         <= 1'b0;
                            end else begin
                                bad_r         <= 1'b1;
                            end
                        end
                        OP_READ: begin
                            data_out_r   <= regs_r[idx_r];
                            parity_out_r <= parity_f(regs_r[idx_r]);
                            bad_r        <= 1'b0;
                        end
                        default: bad_r <= 1'b1;
                    endcase
                end
                default: begin
                end
            endcase
            // Outputs trail the state by one flop: RESP drives them for one cycle.
            ack_n_r   <= (state_r != RESP);
            data_oe_r <= (state_r == RESP) && (op_r == OP_READ);
            err_r     <= (state_r == RESP) && bad_r;
        end
    end

    assign data_out   = data_out_r;
    assign data_oe    = data_oe_r;
    assign parity_out = parity_out_r;
    assign ack_n      = ack_n_r;
    assign err        = err_r;

endmodule
